// File: rtl/lc_pkg.sv
// rtl/lc_pkg.sv - shared widths and types for the lc_* line interface
// Purpose: address/line widths, line type and response entry type used by
//          lc_line_mem and its response FIFO. No ports.
package lc_pkg;

    localparam int LC_ADDR_W    = 64;
    localparam int LC_LINE_BITS = 512;

    typedef logic [LC_LINE_BITS-1:0] lc_line_t;

    typedef struct packed {
        logic [63:0] addr;
        lc_line_t    data;
    } lc_resp_t;

endpackage

// File: rtl/lc_resp_fifo.sv
// rtl/lc_resp_fifo.sv - show-ahead synchronous FIFO of lc_resp_t entries
// Purpose: holds read responses that left the latency pipeline until the
//          consumer takes them; the head entry is always visible on head_o.
// Ports:   clk_in, rst_N        clock, asynchronous active-low reset
//          push_i, push_data_i  write one entry (ignored when full)
//          pop_i                drop the head entry (ignored when empty)
//          head_o               current head entry
//          full_o, empty_o      occupancy flags
module lc_resp_fifo
    import lc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_in,
    input  logic     rst_N,
    input  logic     push_i,
    input  lc_resp_t push_data_i,
    input  logic     pop_i,
    output lc_resp_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    lc_resp_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [IW-1:0]   wr_idx, rd_idx;
    logic            do_push, do_pop;

    generate
        if (DEPTH > 1) begin : g_idx
            assign wr_idx = wr_ptr_q[IW-1:0];
            assign rd_idx = rd_ptr_q[IW-1:0];
        end else begin : g_idx1
            logic unused_ptr_bits;
            assign unused_ptr_bits = ^{wr_ptr_q, rd_ptr_q};
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_idx];

    always_ff @(posedge clk_in or negedge rst_N) begin
        if (!rst_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_idx] <= push_data_i;
    end

endmodule

// File: rtl/lc_line_mem.sv
// rtl/lc_line_mem.sv - line-granular backing memory below the L1 caches
// Purpose: services line reads with fixed latency and in-order responses,
//          commits line writes on accept, and supports a preload port.
// Ports:   clk_in, rst_N                     clock, async active-low reset
//          req_valid/ready/addr/value/we     L1 request channel
//          resp_valid/ready/addr/value       read response channel
//          init_we/addr/value                preload write port
module lc_line_mem
    import lc_pkg::*;
#(
    parameter int LINE_BYTES  = 64,
    parameter int MEM_LINES   = 64,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_N,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic [LC_ADDR_W-1:0] req_addr_in,
    input  lc_line_t             req_value_in,
    input  logic                 req_we_in,
    output logic                 resp_valid_out,
    input  logic                 resp_ready_in,
    output logic [LC_ADDR_W-1:0] resp_addr_out,
    output lc_line_t             resp_value_out,
    input  logic                 init_we_in,
    input  logic [LC_ADDR_W-1:0] init_addr_in,
    input  lc_line_t             init_value_in
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0]     QD_MAX   = CNT_W'(QUEUE_DEPTH);
    localparam logic [LC_ADDR_W-1:0] OFF_MASK = LC_ADDR_W'(LINE_BYTES - 1);

    lc_line_t          mem_q [MEM_LINES];
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [IDX_W-1:0]  req_idx, init_idx;
    logic              rd_acc, wr_acc, resp_pop;
    logic              push, fifo_full, fifo_empty;
    lc_resp_t          rd_entry, push_data, fifo_head;

    // Offset and upper address bits of the preload port select nothing.
    logic unused_init_addr;
    assign unused_init_addr = ^init_addr_in;

    assign req_idx  = req_addr_in[OFF_W +: IDX_W];
    assign init_idx = init_addr_in[OFF_W +: IDX_W];

    // Gating with rst_N keeps ready low while reset is held.
    assign req_ready_out = rst_N && !init_we_in && !fifo_full
                           && (outstanding_q < QD_MAX);
    assign rd_acc   = req_valid_in && req_ready_out && !req_we_in;
    assign wr_acc   = req_valid_in && req_ready_out && req_we_in;
    assign resp_pop = resp_valid_out && resp_ready_in;

    // Response address keeps the upper bits; only the offset is cleared.
    assign rd_entry = '{addr: req_addr_in & ~OFF_MASK, data: mem_q[req_idx]};

    // Preload and request writes never coincide: ready is low under init_we.
    always_ff @(posedge clk_in) begin
        if (init_we_in) begin
            mem_q[init_idx] <= init_value_in;
        end else if (wr_acc) begin
            mem_q[req_idx] <= req_value_in;
        end
    end

    // The accept edge itself is the first latency stage and the FIFO write
    // is the last, so only LATENCY-1 registers sit in between.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push      = rd_acc;
            assign push_data = rd_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_q;
            lc_resp_t           dat_q [LATENCY-1];

            always_ff @(posedge clk_in or negedge rst_N) begin
                if (!rst_N) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= rd_acc;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                dat_q[0] <= rd_entry;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end

            assign push      = vld_q[LATENCY-2];
            assign push_data = dat_q[LATENCY-2];
        end
    endgenerate

    lc_resp_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_resp_fifo (
        .clk_in      (clk_in),
        .rst_N       (rst_N),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (resp_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Outputs read zero while empty so they are defined and stable
    // out of reset and between responses.
    assign resp_valid_out = !fifo_empty;
    assign resp_addr_out  = fifo_empty ? '0 : fifo_head.addr;
    assign resp_value_out = fifo_empty ? '0 : fifo_head.data;

    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_acc && !resp_pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!rd_acc && resp_pop) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N) begin
        if (!rst_N) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_lc_line_mem.sv
// tb/tb_lc_line_mem.sv - directed self-checking bench for lc_line_mem
module tb_lc_line_mem;
    import lc_pkg::*;

    logic           clk_in = 1'b0;
    logic           rst_N  = 1'b1;
    logic           req_valid_in = 1'b0;
    logic           req_ready_out;
    logic [63:0]    req_addr_in = '0;
    lc_line_t       req_value_in = '0;
    logic           req_we_in = 1'b0;
    logic           resp_valid_out;
    logic           resp_ready_in = 1'b0;
    logic [63:0]    resp_addr_out;
    lc_line_t       resp_value_out;
    logic           init_we_in = 1'b0;
    logic [63:0]    init_addr_in = '0;
    lc_line_t       init_value_in = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    lc_line_mem dut (
        .clk_in         (clk_in),
        .rst_N          (rst_N),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_addr_in    (req_addr_in),
        .req_value_in   (req_value_in),
        .req_we_in      (req_we_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_addr_out  (resp_addr_out),
        .resp_value_out (resp_value_out),
        .init_we_in     (init_we_in),
        .init_addr_in   (init_addr_in),
        .init_value_in  (init_value_in)
    );

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic lc_line_t pat(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic preload(input logic [63:0] a, input lc_line_t v);
        init_we_in    = 1'b1;
        init_addr_in  = a;
        init_value_in = v;
        tick();
        init_we_in    = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc, output int n);
        n = 0;
        while (!resp_valid_out && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, resp_valid_out, 1'b1);
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        #2 rst_N = 1'b0;
        #1;
        check("rst_ready", req_ready_out, 1'b0);
        check("rst_valid", resp_valid_out, 1'b0);
        check("rst_addr", resp_addr_out, 64'h0);
        check("rst_value", resp_value_out, '0);
        tick();
        tick();
        rst_N = 1'b1;
        tick();

        // Preload and single read: visible after edge k+3
        preload(64'h0, pat(32'hDEADBEEF));
        req_valid_in  = 1'b1;
        req_we_in     = 1'b0;
        req_addr_in   = 64'h0;
        resp_ready_in = 1'b1;
        #1 check("t1_ready", req_ready_out, 1'b1);
        tick();
        req_valid_in = 1'b0;
        tick();
        tick();
        #1 check("t1_not_early", resp_valid_out, 1'b0);
        tick();
        #1 check("t1_valid", resp_valid_out, 1'b1);
        check("t1_addr", resp_addr_out, 64'h0);
        check("t1_data", resp_value_out, pat(32'hDEADBEEF));
        tick();
        #1 check("t1_popped", resp_valid_out, 1'b0);

        // Offset and aliasing: 0x1234 -> index 8
        tick();
        preload(64'h200, {8{64'h0123456789ABCDEF}});
        req_valid_in = 1'b1;
        req_addr_in  = 64'h1234;
        tick();
        req_valid_in = 1'b0;
        wait_valid("t2_valid", 10, n);
        check("t2_lat", n, 3);
        check("t2_addr", resp_addr_out, 64'h1200);
        check("t2_data", resp_value_out, {8{64'h0123456789ABCDEF}});
        tick();

        // Backpressure with lines 1..5
        for (int i = 1; i <= 5; i++) preload(64'(i * 64), pat(32'hA5000000 | 32'(i)));
        resp_ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_valid_in = 1'b1;
            req_addr_in  = 64'(i * 64);
            #1 check($sformatf("t3_acc%0d", i), req_ready_out, 1'b1);
            tick();
        end
        req_addr_in = 64'h140;
        #1 check("t3_full", req_ready_out, 1'b0);
        repeat (5) tick();
        #1 check("t3_still_full", req_ready_out, 1'b0);
        check("t3_held_valid", resp_valid_out, 1'b1);
        check("t3_held_addr", resp_addr_out, 64'h40);
        check("t3_held_data", resp_value_out, pat(32'hA5000001));
        resp_ready_in = 1'b1;
        tick();
        #1 check("t3_r2", resp_value_out, pat(32'hA5000002));
        check("t3_ready_back", req_ready_out, 1'b1);
        tick();
        req_valid_in = 1'b0;
        #1 check("t3_r3", resp_value_out, pat(32'hA5000003));
        tick();
        #1 check("t3_r4", resp_value_out, pat(32'hA5000004));
        check("t3_r4_addr", resp_addr_out, 64'h100);
        tick();
        #1 check("t3_gap", resp_valid_out, 1'b0);
        tick();
        #1 check("t3_r5_valid", resp_valid_out, 1'b1);
        check("t3_r5", resp_value_out, pat(32'hA5000005));
        check("t3_r5_addr", resp_addr_out, 64'h140);
        tick();

        // Write then read next cycle
        req_valid_in = 1'b1;
        req_we_in    = 1'b1;
        req_addr_in  = 64'hC0;
        req_value_in = '1;
        #1 check("t4_wr_ready", req_ready_out, 1'b1);
        tick();
        req_we_in = 1'b0;
        tick();
        req_valid_in = 1'b0;
        seen = resp_valid_out;
        tick();
        seen = seen | resp_valid_out;
        tick();
        seen = seen | resp_valid_out;
        check("t4_no_wr_resp", seen, 1'b0);
        tick();
        #1 check("t4_valid", resp_valid_out, 1'b1);
        check("t4_data", resp_value_out, {512{1'b1}});
        check("t4_addr", resp_addr_out, 64'hC0);
        tick();

        // Reset mid-operation
        resp_ready_in = 1'b0;
        req_valid_in  = 1'b1;
        req_addr_in   = 64'h40;
        tick();
        req_addr_in   = 64'h80;
        tick();
        req_valid_in  = 1'b0;
        repeat (4) tick();
        #1 check("t5_pre_valid", resp_valid_out, 1'b1);
        rst_N = 1'b0;
        #1 check("t5_rst_valid", resp_valid_out, 1'b0);
        check("t5_rst_ready", req_ready_out, 1'b0);
        tick();
        rst_N = 1'b1;
        #1 check("t5_ready_after", req_ready_out, 1'b1);
        resp_ready_in = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | resp_valid_out;
        end
        check("t5_no_stale", seen, 1'b0);
        req_valid_in = 1'b1;
        req_addr_in  = 64'h0;
        tick();
        req_valid_in = 1'b0;
        wait_valid("t5_valid", 10, n);
        check("t5_retained", resp_value_out, pat(32'hDEADBEEF));
        tick();

        // Preload collision
        init_we_in    = 1'b1;
        init_addr_in  = 64'h240;
        init_value_in = pat(32'h5A5A0009);
        req_valid_in  = 1'b1;
        req_addr_in   = 64'h240;
        #1 check("t6_blocked", req_ready_out, 1'b0);
        tick();
        init_we_in = 1'b0;
        #1 check("t6_ready", req_ready_out, 1'b1);
        tick();
        req_valid_in = 1'b0;
        wait_valid("t6_valid", 10, n);
        check("t6_lat", n, 3);
        check("t6_data", resp_value_out, pat(32'h5A5A0009));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
